// File: rtl/hv_mem_pkg.sv
// Shared types and constants for the hv_mem_emulator block.
package hv_mem_pkg;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } hv_mem_state_e;

  localparam int MAX_READ_LATENCY    = 8;
  localparam int COLLISION_CNT_WIDTH = 16;

  // Number of 8-bit lanes in a data word.
  function automatic int byte_lanes(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/hv_mem_rd_pipe.sv
// Per-port read return delay line: LATENCY stages of valid/data.
// Data stages only load when a valid word arrives, so the output data
// holds its last delivered value while out_valid is low.
module hv_mem_rd_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [LATENCY-1:0]    valid_r;
  logic [DATA_WIDTH-1:0] data_r [LATENCY];

  // Shift valid every cycle; move data forward only alongside a valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_r <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        data_r[i] <= '0;
      end
    end else begin
      valid_r[0] <= in_valid;
      if (in_valid) begin
        data_r[0] <= in_data;
      end
      for (int i = 1; i < LATENCY; i++) begin
        valid_r[i] <= valid_r[i-1];
        if (valid_r[i-1]) begin
          data_r[i] <= data_r[i-1];
        end
      end
    end
  end

  assign out_valid = valid_r[LATENCY-1];
  assign out_data  = data_r[LATENCY-1];

endmodule

// File: rtl/hv_mem_emulator.sv
// Multi-port memory emulator: init sweep after reset, then every port
// may read or write each cycle with byte enables, read-old semantics and
// highest-port-wins resolution of same-address writes per byte lane.
module hv_mem_emulator
  import hv_mem_pkg::*;
#(
  parameter int                     NUM_PORTS    = 2,
  parameter int                     DATA_WIDTH   = 32,
  parameter int                     ADDR_WIDTH   = 10,
  parameter int                     READ_LATENCY = 2,
  parameter logic [DATA_WIDTH-1:0]  INIT_VALUE   = '0
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic [NUM_PORTS-1:0]                     req,
  input  logic [NUM_PORTS-1:0]                     we_n,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0]   be,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]     address,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]     data_i,
  output logic [NUM_PORTS-1:0]                     gnt,
  output logic [NUM_PORTS-1:0]                     rvalid,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]     data_o,
  output logic                                     init_busy,
  output logic [COLLISION_CNT_WIDTH-1:0]           collision_cnt
);

  localparam int DEPTH      = 2 ** ADDR_WIDTH;
  localparam int LANES      = byte_lanes(DATA_WIDTH);
  localparam int PIPE_DEPTH = (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY :
                              ((READ_LATENCY < 1) ? 1 : READ_LATENCY);

  hv_mem_state_e                  state_r;
  logic [ADDR_WIDTH-1:0]          init_addr_r;
  logic                           init_busy_r;
  logic [COLLISION_CNT_WIDTH-1:0] collision_cnt_r;
  logic                           ready_s;
  logic                           collision_s;
  logic [NUM_PORTS-1:0]           wr_acc_s;
  logic [NUM_PORTS-1:0]           rd_acc_s;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rd_data_s;
  logic [DATA_WIDTH-1:0]          mem [DEPTH];

  assign ready_s  = (state_r == ST_READY);
  assign gnt      = req & {NUM_PORTS{ready_s}};
  assign wr_acc_s = gnt & ~we_n;
  assign rd_acc_s = gnt & we_n;

  // Flag a cycle in which any two accepted writes share an address.
  always_comb begin
    collision_s = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int j = i + 1; j < NUM_PORTS; j++) begin
        if (wr_acc_s[i] && wr_acc_s[j] && (address[i] == address[j])) begin
          collision_s = 1'b1;
        end else begin
          collision_s = collision_s;
        end
      end
    end
  end

  // Init sweep state machine: one word per cycle, then serve traffic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_INIT;
      init_addr_r <= '0;
      init_busy_r <= 1'b1;
    end else begin
      case (state_r)
        ST_INIT: begin
          if (init_addr_r == ADDR_WIDTH'(DEPTH - 1)) begin
            state_r     <= ST_READY;
            init_busy_r <= 1'b0;
            init_addr_r <= '0;
          end else begin
            init_addr_r <= init_addr_r + ADDR_WIDTH'(1);
          end
        end
        ST_READY: begin
          init_busy_r <= 1'b0;
        end
        default: begin
          state_r     <= ST_INIT;
          init_addr_r <= '0;
          init_busy_r <= 1'b1;
        end
      endcase
    end
  end

  // Saturating count of same-address write collisions.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      collision_cnt_r <= '0;
    end else if (collision_s && (collision_cnt_r != {COLLISION_CNT_WIDTH{1'b1}})) begin
      collision_cnt_r <= collision_cnt_r + COLLISION_CNT_WIDTH'(1);
    end else begin
      collision_cnt_r <= collision_cnt_r;
    end
  end

  // Storage array: init sweep writes, otherwise per-lane port writes.
  // Ports are applied in ascending order so the highest enabled port wins a lane.
  always_ff @(posedge clk) begin
    if (state_r == ST_INIT) begin
      mem[init_addr_r] <= INIT_VALUE;
    end else begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        for (int b = 0; b < LANES; b++) begin
          if (wr_acc_s[k] && be[k][b]) begin
            mem[address[k]][8*b +: 8] <= data_i[k][8*b +: 8];
          end
        end
      end
    end
  end

  // Read data is sampled before this edge's writes land, giving read-old behaviour.
  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    assign rd_data_s[k] = mem[address[k]];

    hv_mem_rd_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .LATENCY    (PIPE_DEPTH)
    ) u_rd_pipe (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (rd_acc_s[k]),
      .in_data   (rd_data_s[k]),
      .out_valid (rvalid[k]),
      .out_data  (data_o[k])
    );
  end

  assign init_busy     = init_busy_r;
  assign collision_cnt = collision_cnt_r;

endmodule

// File: tb/tb_hv_mem_emulator.sv
// Self-checking bench for hv_mem_emulator with a read scoreboard.
module tb_hv_mem_emulator;

  localparam int NP  = 2;
  localparam int DW  = 32;
  localparam int AW  = 10;
  localparam int LAT = 2;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [NP-1:0]       req;
  logic [NP-1:0]       we_n;
  logic [NP-1:0][3:0]  be;
  logic [NP-1:0][AW-1:0] address;
  logic [NP-1:0][DW-1:0] data_i;
  logic [NP-1:0]       gnt;
  logic [NP-1:0]       rvalid;
  logic [NP-1:0][DW-1:0] data_o;
  logic                init_busy;
  logic [15:0]         collision_cnt;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        exp_q [NP][$];
  logic [31:0] model [1024];
  logic [31:0] last_data [NP];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          n_init;

  hv_mem_emulator #(
    .NUM_PORTS    (NP),
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .READ_LATENCY (LAT),
    .INIT_VALUE   (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req           (req),
    .we_n          (we_n),
    .be            (be),
    .address       (address),
    .data_i        (data_i),
    .gnt           (gnt),
    .rvalid        (rvalid),
    .data_o        (data_o),
    .init_busy     (init_busy),
    .collision_cnt (collision_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: pop expectations as rvalid appears, check data, cycle and hold.
  always @(negedge clk) begin
    if (!reset_n) begin
      for (int p = 0; p < NP; p++) last_data[p] = 32'h0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (rvalid[p] === 1'b1) begin
          if (exp_q[p].size() == 0) begin
            chk("unexpected_rvalid", {31'h0, rvalid[p]}, 32'h0);
          end else begin
            chk("rd_data", data_o[p], exp_q[p][0].data);
            chk("rd_cycle", cyc, exp_q[p][0].due);
            last_data[p] = exp_q[p][0].data;
            void'(exp_q[p].pop_front());
          end
        end else begin
          chk("data_hold", data_o[p], last_data[p]);
          if (exp_q[p].size() != 0 && exp_q[p][0].due <= cyc) begin
            chk("rvalid_missing", {31'h0, rvalid[p]}, 32'h1);
            void'(exp_q[p].pop_front());
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    req = '0; we_n = '1; be = '0; address = '0; data_i = '0;
  endtask

  // One cycle of traffic; reads capture the model before this cycle's writes.
  task automatic cyc_op(input logic [NP-1:0] rq, input logic [NP-1:0] wn,
                        input logic [NP-1:0][3:0] b, input logic [NP-1:0][AW-1:0] a,
                        input logic [NP-1:0][DW-1:0] d);
    exp_t e;
    req = rq; we_n = wn; be = b; address = a; data_i = d;
    for (int p = 0; p < NP; p++) begin
      if (rq[p] && wn[p]) begin
        e.data = model[a[p]];
        e.due  = cyc + LAT;
        exp_q[p].push_back(e);
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (rq[p] && !wn[p]) begin
        for (int l = 0; l < 4; l++) begin
          if (b[p][l]) model[a[p]][8*l +: 8] = d[p][8*l +: 8];
        end
      end
    end
    step();
    idle();
  endtask

  // Hostile traffic during the sweep: writes that would collide if not ignored.
  task automatic wait_init(output int n);
    n = 0;
    req = 2'b11; we_n = 2'b00; be = {4'hF, 4'hF};
    address = {10'h030, 10'h030}; data_i = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
    while (init_busy === 1'b1 && n < 2000) begin
      chk("gnt_in_init", {30'h0, gnt}, 32'h0);
      n++;
      step();
    end
    idle();
  endtask

  task automatic drain();
    repeat (LAT + 3) step();
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    for (int i = 0; i < 1024; i++) model[i] = 32'h0;
    req = 2'b11;
    repeat (3) step();
    chk("rst_gnt", {30'h0, gnt}, 32'h0);
    chk("rst_busy", {31'h0, init_busy}, 32'h1);
    chk("rst_rvalid", {30'h0, rvalid}, 32'h0);
    chk("rst_data0", data_o[0], 32'h0);
    chk("rst_cnt", {16'h0, collision_cnt}, 32'h0);

    // Init sweep length and ignored traffic
    reset_n = 1'b1;
    wait_init(n_init);
    chk("init_len", n_init, 32'd1024);
    chk("init_cnt", {16'h0, collision_cnt}, 32'h0);
    cyc_op(2'b11, 2'b11, '0, {10'h3FF, 10'h000}, '0);
    cyc_op(2'b11, 2'b11, '0, {10'h030, 10'h005}, '0);
    drain();

    // Latency and back-to-back reads
    cyc_op(2'b01, 2'b10, {4'h0, 4'hF}, {10'h0, 10'h010}, {32'h0, 32'hDEAD_BEEF});
    for (int i = 0; i < 4; i++) cyc_op(2'b01, 2'b11, '0, {10'h0, 10'h010}, '0);
    drain();

    // Byte lanes, including an all-zero-enable write
    cyc_op(2'b01, 2'b10, {4'h0, 4'hF}, {10'h0, 10'h020}, {32'h0, 32'h1122_3344});
    cyc_op(2'b01, 2'b10, {4'h0, 4'h5}, {10'h0, 10'h020}, {32'h0, 32'hAABB_CCDD});
    cyc_op(2'b10, 2'b11, '0, {10'h020, 10'h0}, '0);
    cyc_op(2'b01, 2'b10, {4'h0, 4'h0}, {10'h0, 10'h020}, {32'h0, 32'hFFFF_FFFF});
    cyc_op(2'b01, 2'b11, '0, {10'h0, 10'h020}, '0);
    drain();

    // Same-address write collisions
    cyc_op(2'b11, 2'b00, {4'hF, 4'hF}, {10'h030, 10'h030}, {32'h2, 32'h1});
    chk("coll_cnt1", {16'h0, collision_cnt}, 32'h1);
    cyc_op(2'b01, 2'b11, '0, {10'h0, 10'h030}, '0);
    cyc_op(2'b11, 2'b00, {4'h3, 4'hF}, {10'h031, 10'h031}, {32'h5555_5555, 32'hAAAA_AAAA});
    chk("coll_cnt2", {16'h0, collision_cnt}, 32'h2);
    cyc_op(2'b11, 2'b00, {4'h0, 4'hF}, {10'h033, 10'h032}, {32'h7, 32'h6});
    chk("no_coll", {16'h0, collision_cnt}, 32'h2);
    cyc_op(2'b10, 2'b11, '0, {10'h031, 10'h0}, '0);
    // Read-old: port 1 reads while port 0 writes the same address
    cyc_op(2'b01, 2'b10, {4'h0, 4'hF}, {10'h0, 10'h040}, {32'h0, 32'h1234_5678});
    cyc_op(2'b11, 2'b10, {4'h0, 4'hF}, {10'h040, 10'h040}, {32'h0, 32'h9ABC_DEF0});
    cyc_op(2'b10, 2'b11, '0, {10'h040, 10'h0}, '0);
    drain();

    // Reset with two reads in flight
    cyc_op(2'b11, 2'b11, '0, {10'h031, 10'h030}, '0);
    reset_n = 1'b0;
    exp_q[0].delete();
    exp_q[1].delete();
    for (int i = 0; i < 1024; i++) model[i] = 32'h0;
    req = 2'b11;
    step();
    chk("mid_rst_rvalid", {30'h0, rvalid}, 32'h0);
    chk("mid_rst_data1", data_o[1], 32'h0);
    chk("mid_rst_cnt", {16'h0, collision_cnt}, 32'h0);
    chk("mid_rst_gnt", {30'h0, gnt}, 32'h0);
    chk("mid_rst_busy", {31'h0, init_busy}, 32'h1);
    reset_n = 1'b1;
    wait_init(n_init);
    chk("reinit_len", n_init, 32'd1024);
    chk("reinit_cnt", {16'h0, collision_cnt}, 32'h0);
    cyc_op(2'b11, 2'b11, '0, {10'h040, 10'h030}, '0);
    drain();
    chk("sb_empty", exp_q[0].size() + exp_q[1].size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hv_mem_emulator.md
HV_MEM_EMULATOR -- requirements
Module: hv_mem_emulator

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2: number of independent access ports (1..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32: word width; a multiple of 8.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10: memory depth is 2**ADDR_WIDTH words.
REQ-004 SHALL have parameter READ_LATENCY, default 2: cycles from read acceptance to rvalid (1..8).
REQ-005 SHALL have parameter INIT_VALUE, default 0: word written to every location during initialisation.
REQ-006 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-007 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port req  input  [NUM_PORTS]  per-port transaction request.
REQ-009 SHALL have port we_n  input  [NUM_PORTS]  per-port write enable, active-low; 1 = read.
REQ-010 SHALL have port be  input  [DATA_WIDTH/8] x NUM_PORTS  per-port byte enables for writes.
REQ-011 SHALL have port address  input  [ADDR_WIDTH] x NUM_PORTS  per-port word address.
REQ-012 SHALL have port data_i  input  [DATA_WIDTH] x NUM_PORTS  per-port write data.
REQ-013 SHALL have port gnt  output  [NUM_PORTS]  per-port grant; transaction accepted when req and gnt are high at a rising edge.
REQ-014 SHALL have port rvalid  output  [NUM_PORTS]  per-port read-data-valid strobe.
REQ-015 SHALL have port data_o  output  [DATA_WIDTH] x NUM_PORTS  per-port read data.
REQ-016 SHALL have port init_busy  output  1  high while the initialisation sweep runs.
REQ-017 SHALL have port collision_cnt  output  16  saturating count of cycles with a same-address write collision.

Function
REQ-018 SHALL implement FSM states INIT and READY; reset enters INIT.
REQ-019 SHALL in INIT write INIT_VALUE to address 0..2**ADDR_WIDTH-1, one word per cycle, then enter READY after exactly 2**ADDR_WIDTH cycles.
REQ-020 SHALL drive init_busy = 1 in INIT and 0 in READY.
REQ-021 SHALL drive gnt[k] = req[k] AND (state == READY), combinationally; every port can be granted every cycle.
REQ-022 SHALL present data for a read accepted at edge t on data_o[k], with rvalid[k] = 1, for exactly one cycle READ_LATENCY edges later; fully pipelined at one read per port per cycle.
REQ-023 SHALL return pre-write contents when a read and a write to the same address are accepted at the same edge (read-old).
REQ-024 SHALL update only the byte lanes with be = 1 on an accepted write; be = 0 lanes keep their value; be = 0 everywhere is a legal no-op write.
REQ-025 SHALL resolve same-address, same-edge writes per byte lane: the highest-numbered port with that lane enabled wins.
REQ-026 SHALL increment collision_cnt by 1 on each edge where two or more accepted writes target the same address (regardless of be), saturating at 16'hFFFF.
REQ-027 SHALL produce no rvalid for accepted writes.
REQ-028 SHALL hold data_o[k] at its last value while rvalid[k] = 0.
REQ-029 SHALL ignore req, we_n, be, address and data_i while in INIT.

Reset
REQ-030 SHALL on reset_n low immediately clear rvalid, data_o, collision_cnt and the read pipeline, discarding in-flight reads.
REQ-031 SHALL on reset_n low force gnt to 0 and init_busy to 1.
REQ-032 SHALL restart the INIT sweep from address 0 when reset_n is released, including after reset asserted mid-sweep or mid-traffic.

Structure
REQ-033 SHALL place the state enum (INIT, READY), MAX_READ_LATENCY = 8, COLLISION_CNT_WIDTH = 16 and the byte-lane count function in shared package hv_mem_pkg.
REQ-034 SHALL instantiate one sub-module hv_mem_rd_pipe per port: a READ_LATENCY-deep valid/data delay line with asynchronous reset.

Verification
REQ-035 SHALL cover init: release reset, DEPTH = 1024 -> init_busy high 1024 cycles, gnt = 0 throughout, then all reads return 0.
REQ-036 SHALL cover latency: port 0 writes 0xDEADBEEF to 0x010, reads 0x010 back-to-back 4 times -> 4 consecutive rvalid pulses starting 2 cycles after the first read, each 0xDEADBEEF.
REQ-037 SHALL cover byte lanes: write 0x11223344 at 0x20, then 0xAABBCCDD with be = 0101 -> readback 0x11BB33DD.
REQ-038 SHALL cover collision: port 0 writes 0x1 and port 1 writes 0x2 to 0x30 at the same edge -> readback 0x2, collision_cnt = 1; port 1 read and port 0 write to 0x40 at the same edge -> read returns old value.
REQ-039 SHALL cover reset mid-operation: assert reset_n with 2 reads in flight -> no rvalid after release; INIT reruns for the full 1024 cycles; collision_cnt = 0.
